reg_file_8x16: RTL and testbench

REG_FILE_8X16 -- requirements
Module: reg_file_8x16

---
 rtl/reg_file_8x16.sv | 40 ++++
 tb/tb_reg_file_8x16.sv | 132 +++++++++++++
 2 files changed

// File: rtl/reg_file_8x16.sv
// reg_file_8x16: 8-entry register file, R0 hardwired to zero, two combinational read ports with write-through bypass
module reg_file_8x16 #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  LOAD,
  input  logic [DEPTH_LOG2-1:0] WA,
  input  logic [DATA_W-1:0]     WD,
  input  logic [DEPTH_LOG2-1:0] RA1,
  input  logic [DEPTH_LOG2-1:0] RA2,
  output logic [DATA_W-1:0]     RD1,
  output logic [DATA_W-1:0]     RD2
);
  localparam int N = 2 ** DEPTH_LOG2;
  logic [DATA_W-1:0] regs_q [N];
  logic [DATA_W-1:0] regs_d [N];
  logic              wr_en;
  assign wr_en = LOAD && clr_n && (WA != '0);
  // next-state: only the addressed register takes WD; R0 is pinned to zero
  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[WA] = WD;
    regs_d[0] = '0;
  end
  // register array, cleared asynchronously so reads drop to zero at once
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < N; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end
  // read ports forward the pending write so a same-cycle read sees new data
  always_comb begin
    RD1 = (wr_en && RA1 == WA) ? WD : regs_q[RA1];
    RD2 = (wr_en && RA2 == WA) ? WD : regs_q[RA2];
  end
endmodule

// File: tb/tb_reg_file_8x16.sv
// tb_reg_file_8x16: scoreboard bench for reg_file_8x16 against an array model
module tb_reg_file_8x16;
  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        load = 1'b0;
  logic [2:0]  wa = '0, ra1 = '0, ra2 = '0;
  logic [15:0] wd = '0;
  logic [15:0] rd1, rd2;

  reg_file_8x16 dut (
    .clk(clk), .clr_n(clr_n), .LOAD(load), .WA(wa), .WD(wd),
    .RA1(ra1), .RA2(ra2), .RD1(rd1), .RD2(rd2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] e1;
    logic [15:0] e2;
    string       nm;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m [8];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [15:0] model_rd(input logic [2:0] a);
    if (clr_n && load && wa != 3'd0 && a == wa) return wd;
    return m[a];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) m[i] = 16'h0000;
  endfunction

  task automatic expect_now(input string nm);
    exp_t e;
    e.e1 = model_rd(ra1);
    e.e2 = model_rd(ra2);
    e.nm = nm;
    q.push_back(e);
  endtask

  // one cycle: drive at posedge+1, queue expected reads, then take the edge
  task automatic cyc(input logic r, input logic l, input logic [2:0] a_w,
                     input logic [15:0] d, input logic [2:0] a1, input logic [2:0] a2,
                     input string nm, input bit rst_at_edge = 1'b0);
    clr_n = r;
    if (!r) model_clear();
    load = l; wa = a_w; wd = d; ra1 = a1; ra2 = a2;
    expect_now(nm);
    @(posedge clk);
    if (rst_at_edge) begin
      clr_n = 1'b0;
      model_clear();
    end else if (clr_n && load && wa != 3'd0) begin
      m[wa] = wd;
    end
    #1;
  endtask

  // monitor: outputs are combinational, so every queued vector is checked mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        vectors++;
        if (rd1 !== e.e1 || rd2 !== e.e2) begin
          miscompares++;
          $display("FAIL %s: RD1=%h RD2=%h expected RD1=%h RD2=%h", e.nm, rd1, rd2, e.e1, e.e2);
        end
      end
    end
  end

  initial begin
    model_clear();
    @(posedge clk); #1;
    cyc(1'b0, 1'b1, 3'd3, 16'h1111, 3'd3, 3'd5, "reset_state");
    cyc(1'b1, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd7, "after_release");
    // walking ones into R1..R7
    for (int i = 1; i < 8; i++)
      cyc(1'b1, 1'b1, 3'(i), 16'h0001 << i, 3'(i), 3'(i - 1), "walk_write");
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b0, 3'd0, 16'h0000, 3'(i), 3'(i), "walk_read");
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b0, 3'd0, 16'h0000, 3'(i), 3'(7 - i), "walk_read_x");
    // R0 protection
    cyc(1'b1, 1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, "r0_during");
    cyc(1'b1, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, "r0_after");
    // bypass on both ports
    cyc(1'b1, 1'b1, 3'd5, 16'h1234, 3'd1, 3'd2, "r5_write");
    cyc(1'b1, 1'b1, 3'd5, 16'hBEEF, 3'd5, 3'd5, "bypass_before");
    cyc(1'b1, 1'b0, 3'd5, 16'h0000, 3'd5, 3'd5, "bypass_after");
    // LOAD=0 hold on R2
    for (int i = 0; i < 16; i++)
      cyc(1'b1, 1'b0, 3'd2, 16'hDEAD, 3'd2, 3'd5, "load0_hold");
    // back-to-back writes to one address
    cyc(1'b1, 1'b1, 3'd6, 16'hAAAA, 3'd6, 3'd0, "b2b_first");
    cyc(1'b1, 1'b1, 3'd6, 16'hCCCC, 3'd6, 3'd6, "b2b_second");
    cyc(1'b1, 1'b0, 3'd0, 16'h0000, 3'd6, 3'd6, "b2b_result");
    // asynchronous reset between edges
    cyc(1'b1, 1'b1, 3'd3, 16'hA5A5, 3'd3, 3'd3, "r3_write");
    load = 1'b0; ra1 = 3'd3; ra2 = 3'd5;
    #2 clr_n = 1'b0;
    model_clear();
    #1 expect_now("async_reset");
    @(posedge clk); #1;
    cyc(1'b0, 1'b1, 3'd3, 16'hFFFF, 3'd3, 3'd3, "reset_no_bypass");
    cyc(1'b1, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, "reset_ignored_load");
    cyc(1'b1, 1'b1, 3'd3, 16'h7E57, 3'd3, 3'd1, "first_write_after_reset");
    cyc(1'b1, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, "first_write_result");
    // reset coincident with a write edge loses the write
    cyc(1'b1, 1'b1, 3'd4, 16'h5555, 3'd4, 3'd4, "write_at_reset", 1'b1);
    cyc(1'b1, 1'b0, 3'd0, 16'h0000, 3'd4, 3'd3, "reset_during_write");
    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(0, 39) != 0), 1'($urandom), 3'($urandom), 16'($urandom),
          3'($urandom), 3'($urandom), "random");
    cyc(1'b1, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd2, "final");
    @(negedge clk); #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d vectors left unchecked, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
